// File: rtl/pipe_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_lsu : load/store unit, word memory port, read-modify-write      |
// |            for byte/half stores, lane extraction for loads.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;

  logic        accept, req_err;
  logic [4:0]  shamt;
  logic [31:0] rd_shifted, load_val, lane_mask, lane_data, store_word;

  assign accept = req_valid && (state_q == S_IDLE);
  assign shamt  = {addr_q[1:0], 3'b000};

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sub-word stores need the old word first, so they go through RD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (req_err)                              state_d = S_DONE;
        else if (!req_we || req_size != SZ_WORD)  state_d = S_RD;
        else                                      state_d = S_WR;
      end
      S_RD:   if (mem_ack) state_d = we_q ? S_WR : S_DONE;
      S_WR:   if (mem_ack) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state_q == S_RD && mem_ack) begin
        if (we_q) merge_q <= mem_rdata;
        else      rdata_q <= load_val;
      end
    end
  end

  // Aligned accesses let one shifter serve both byte and half lanes.
  assign rd_shifted = mem_rdata >> shamt;

  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & rd_shifted[7]}},  rd_shifted[7:0]};
      SZ_HALF: load_val = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    lane_data = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << shamt;
        lane_data = {24'h0, wdata_q[7:0]} << shamt;
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_FFFF << shamt;
        lane_data = {16'h0, wdata_q[15:0]} << shamt;
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata_q;
      end
    endcase
    store_word = (merge_q & ~lane_mask) | lane_data;
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_req    = (state_q == S_RD) || (state_q == S_WR);
    mem_we     = (state_q == S_WR);
    mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata  = (state_q == S_WR) ? store_word : '0;
    resp_valid = (state_q == S_DONE);
    resp_err   = (state_q == S_DONE) && err_q;
    resp_rdata = rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_lsu : directed bench with a word-memory model and responder. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_lsu;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl_mem [logic [31:0]];

  pipe_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    logic [31:0] w, v;
    int sh;
    w = rd_word({a[31:2], 2'b00});
    v = w;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      v  = (w >> sh) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      v  = (w >> sh) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w, m;
    int sh;
    w = rd_word({a[31:2], 2'b00});
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'h0000_00FF << sh;
      return (w & ~m) | ((d & 32'h0000_00FF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      m  = 32'h0000_FFFF << sh;
      return (w & ~m) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  // One transaction: drive request, act as memory, check every cycle until the response.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] d, input int lat1, input int lat2,
                        input bit lit, input logic [31:0] lit_val, input int lit_lat);
    bit          err, rmw, done, exp_we;
    int          n_acc, exp_lat, phase, cnt, lat_cur;
    logic [31:0] exp_rd, exp_wd, waddr;
    err     = model_err(a, sz);
    rmw     = we && (sz != 2'b10);
    waddr   = {a[31:2], 2'b00};
    exp_wd  = we ? model_store(a, sz, d) : 32'h0;
    exp_rd  = (we || err) ? 32'h0 : model_load(a, sz, sgn);
    n_acc   = err ? 0 : (rmw ? 2 : 1);
    exp_lat = err ? 1 : (rmw ? lat1 + lat2 + 1 : lat1 + 1);
    phase   = 0;
    cnt     = 0;
    done    = 1'b0;

    @(negedge clk);
    check({tag, ".ready_idle"}, {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sgn;
    req_addr = $urandom; req_wdata = $urandom;

    for (int k = 1; k <= 200 && !done; k++) begin
      if (k > 1) @(negedge clk);
      mem_ack = 1'b0;
      if (resp_valid) begin
        check({tag, ".latency"}, k, exp_lat);
        check({tag, ".resp_err"}, {31'b0, resp_err}, {31'b0, err});
        check({tag, ".resp_rdata"}, resp_rdata, exp_rd);
        check({tag, ".accesses"}, phase, n_acc);
        check({tag, ".ready_done"}, {31'b0, req_ready}, 32'h0);
        if (lit) begin
          check({tag, ".lit_value"}, we ? mdl_mem[waddr] : resp_rdata, lit_val);
          if (lit_lat > 0) check({tag, ".lit_latency"}, k, lit_lat);
        end
        done = 1'b1;
      end else if (mem_req) begin
        check({tag, ".ready_busy"}, {31'b0, req_ready}, 32'h0);
        if (phase >= n_acc) begin
          check({tag, ".extra_access"}, phase, n_acc);
        end else begin
          exp_we = we && !(rmw && phase == 0);
          check({tag, ".mem_addr"}, mem_addr, waddr);
          check({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, exp_we});
          if (exp_we) check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
          lat_cur = (phase == 0) ? lat1 : lat2;
          cnt++;
          if (cnt >= lat_cur) begin
            mem_ack = 1'b1;
            if (exp_we) mdl_mem[waddr] = exp_wd;
            else        mem_rdata = rd_word(waddr);
            phase++;
            cnt = 0;
          end
        end
      end else begin
        check({tag, ".ready_busy"}, {31'b0, req_ready}, 32'h0);
      end
    end
    mem_ack = 1'b0;
    if (!done) check({tag, ".timeout"}, 32'h0, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  {31'b0, req_ready},  32'h1);
    check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'h0);
    check({tag, ".resp_err"},   {31'b0, resp_err},   32'h0);
    check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
    check({tag, ".mem_req"},    {31'b0, mem_req},    32'h0);
    check({tag, ".mem_we"},     {31'b0, mem_we},     32'h0);
    check({tag, ".mem_addr"},   mem_addr,  32'h0);
    check({tag, ".mem_wdata"},  mem_wdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    mdl_mem[32'h100] = 32'h8000_1234;
    mdl_mem[32'h200] = 32'h1122_3344;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    do_txn("ld_half_s",   1'b0, 2'b01, 1'b1, 32'h102, 32'h0,         3, 0, 1'b1, 32'hFFFF_8000, 4);
    do_txn("st_byte",     1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 2, 1, 1'b1, 32'h1122_AB44, 4);
    do_txn("misal_word",  1'b0, 2'b10, 1'b0, 32'h302, 32'h0,         1, 0, 1'b1, 32'h0,         1);
    do_txn("stall_ld",    1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        11, 0, 1'b1, 32'h8000_1234, 12);
    do_txn("st_word",     1'b1, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF, 1, 0, 1'b1, 32'hDEAD_BEEF, 2);
    do_txn("ld_byte_u",   1'b0, 2'b00, 1'b0, 32'h403, 32'h0,         2, 0, 1'b1, 32'h0000_00DE, 3);
    do_txn("ld_byte_s",   1'b0, 2'b00, 1'b1, 32'h403, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFDE, 2);
    do_txn("st_half",     1'b1, 2'b01, 1'b0, 32'h402, 32'hFFFF_5555, 1, 3, 1'b1, 32'h5555_BEEF, 5);
    do_txn("ld_half_u",   1'b0, 2'b01, 1'b0, 32'h100, 32'h0,         1, 0, 1'b1, 32'h0000_1234, 2);
    do_txn("st_byte_hi",  1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_0077, 1, 2, 1'b1, 32'h7722_AB44, 4);
    do_txn("illegal_sz",  1'b0, 2'b11, 1'b1, 32'h100, 32'h0,         1, 0, 1'b0, 32'h0,         0);
    do_txn("misal_half",  1'b1, 2'b01, 1'b0, 32'h101, 32'h1234_5678, 1, 1, 1'b0, 32'h0,         0);
    do_txn("ld_word",     1'b0, 2'b10, 1'b1, 32'h400, 32'h0,         2, 0, 1'b0, 32'h0,         0);

    // Abandon a word store mid-WR with an asynchronous reset.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h500; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr.mem_req", {31'b0, mem_req}, 32'h1);
    check("rst_wr.mem_we",  {31'b0, mem_we},  32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wr");
    @(negedge clk);
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_wr.no_resp", {31'b0, resp_valid}, 32'h0);
      check("rst_wr.idle",    {31'b0, req_ready},  32'h1);
      @(negedge clk);
    end

    do_txn("post_rst_ld", 1'b0, 2'b00, 1'b1, 32'h201, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFAB, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
